// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit counter BHT plus direct-mapped BTB, predictions piped F->D->E.
// Optional gshare history indexing of the BHT when BP_GSHARE_EN is defined.
module branch_predictor #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic            BranchE,
    input  logic            NeedBranchE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            MispredictE,
    output logic [XLEN-1:0] PCRedirectE
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = XLEN - IDX_W - 2;

    function automatic logic [1:0] satInc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] satDec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic             btbValid  [ENTRIES];
    logic [TAG_W-1:0] btbTag    [ENTRIES];
    logic [XLEN-1:0]  btbTarget [ENTRIES];
    logic [1:0]       bhtCnt    [ENTRIES];

    logic [IDX_W-1:0] idxF, idxE, bhtIdxF, bhtIdxE;
    logic [TAG_W-1:0] tagF, tagE;
    logic             hitF, hitE, train, mispredict;
    logic             predTaken_p1, predTaken_p2;
    logic [XLEN-1:0]  predTarget_p1, predTarget_p2;
    logic             unusedPcBits;

    assign idxF  = PCF[IDX_W+1:2];
    assign tagF  = PCF[XLEN-1:IDX_W+2];
    assign idxE  = PCE[IDX_W+1:2];
    assign tagE  = PCE[XLEN-1:IDX_W+2];
    assign train = BranchE && !StallE;
    assign unusedPcBits = ^{PCF[1:0], PCE[1:0]};

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr, ghr_p1, ghr_p2;

    assign bhtIdxF = idxF ^ ghr;
    assign bhtIdxE = idxE ^ ghr_p2;

    // History is committed only from resolved branches, so it never needs repair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr    <= '0;
            ghr_p1 <= '0;
            ghr_p2 <= '0;
        end else begin
            if (train)
                ghr <= {ghr[IDX_W-2:0], NeedBranchE};
            if (FlushD)
                ghr_p1 <= '0;
            else if (!StallD)
                ghr_p1 <= ghr;
            if (FlushE)
                ghr_p2 <= '0;
            else if (!StallE)
                ghr_p2 <= ghr_p1;
        end
    end
`else
    assign bhtIdxF = idxF;
    assign bhtIdxE = idxE;
`endif

    // ---- F: lookup sees pre-update table contents ----
    assign hitF        = btbValid[idxF] && (btbTag[idxF] == tagF);
    assign hitE        = btbValid[idxE] && (btbTag[idxE] == tagE);
    assign PredTakenF  = hitF && bhtCnt[bhtIdxF][1];
    assign PredTargetF = hitF ? btbTarget[idxF] : '0;

    // ---- F->D->E prediction registers ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            predTaken_p1  <= 1'b0;
            predTarget_p1 <= '0;
            predTaken_p2  <= 1'b0;
            predTarget_p2 <= '0;
        end else begin
            if (FlushD) begin
                predTaken_p1  <= 1'b0;
                predTarget_p1 <= '0;
            end else if (!StallD) begin
                predTaken_p1  <= PredTakenF;
                predTarget_p1 <= PredTargetF;
            end
            if (FlushE) begin
                predTaken_p2  <= 1'b0;
                predTarget_p2 <= '0;
            end else if (!StallE) begin
                predTaken_p2  <= predTaken_p1;
                predTarget_p2 <= predTarget_p1;
            end
        end
    end

    // ---- E: compare prediction with resolution ----
    always_comb begin
        mispredict = 1'b0;
        if (BranchE)
            mispredict = (NeedBranchE != predTaken_p2) ||
                         (NeedBranchE && predTaken_p2 && (predTarget_p2 != PCTargetE));
        else
            mispredict = predTaken_p2;
        MispredictE = mispredict && !reset;
        PCRedirectE = '0;
        if (MispredictE)
            PCRedirectE = (BranchE && NeedBranchE) ? PCTargetE : PCPlus4E;
    end

    // ---- E: table training ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btbValid[i] <= 1'b0;
                bhtCnt[i]   <= 2'b01;
            end
        end else if (train) begin
            if (NeedBranchE) begin
                btbValid[idxE]  <= 1'b1;
                bhtCnt[bhtIdxE] <= hitE ? satInc(bhtCnt[bhtIdxE]) : 2'b10;
            end else begin
                bhtCnt[bhtIdxE] <= satDec(bhtCnt[bhtIdxE]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (train && NeedBranchE) begin
            btbTag[idxE]    <= tagE;
            btbTarget[idxE] <= PCTargetE;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios then randomized traffic against a table-level reference model.
// Honors BP_GSHARE_EN the same way the design does.
module tb_branch_predictor;
    localparam int XLEN  = 32;
    localparam int IDX_W = 6;
    localparam int ENT   = 64;
`ifdef BP_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] PCF, PredTargetF, PCE, PCPlus4E, PCTargetE, PCRedirectE;
    logic            PredTakenF, StallD, FlushD, StallE, FlushE, BranchE, NeedBranchE, MispredictE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(XLEN), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .StallD(StallD), .FlushD(FlushD), .StallE(StallE), .FlushE(FlushE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .BranchE(BranchE), .NeedBranchE(NeedBranchE),
        .PCTargetE(PCTargetE), .MispredictE(MispredictE), .PCRedirectE(PCRedirectE)
    );

    // Reference model state: tables as plain arrays, pipeline as carried values.
    bit          mValid [ENT];
    logic [31:0] mTag   [ENT];
    logic [31:0] mTgt   [ENT];
    int          mCnt   [ENT];
    int          mGhr;
    bit          dTaken, eTaken;
    logic [31:0] dTgt, eTgt;
    int          dGhr, eGhr;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int cntSlot(input logic [31:0] pc, input int g);
        return GSHARE ? ((slot(pc) ^ g) % 64) : slot(pc);
    endfunction

    function automatic bit mHit(input logic [31:0] pc);
        return mValid[slot(pc)] && (mTag[slot(pc)] == pc / 256);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENT; i++) begin
            mValid[i] = 1'b0;
            mCnt[i]   = 1;
        end
        mGhr = 0; dTaken = 0; eTaken = 0; dTgt = 0; eTgt = 0; dGhr = 0; eGhr = 0;
    endtask

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tg, obs, exp);
        end
    endtask

    task automatic setIn(input logic [31:0] pcf, input bit sd, input bit fd, input bit se, input bit fe,
                         input logic [31:0] pce, input bit br, input bit nb, input logic [31:0] tgt);
        PCF = pcf; StallD = sd; FlushD = fd; StallE = se; FlushE = fe;
        PCE = pce; PCPlus4E = pce + 4; BranchE = br; NeedBranchE = nb; PCTargetE = tgt;
    endtask

    task automatic settle(input string tg);
        bit          h, expT, expM;
        logic [31:0] expTgt, expR;
        #1;
        h      = !reset && mHit(PCF);
        expT   = h && (mCnt[cntSlot(PCF, mGhr)] >= 2);
        expTgt = h ? mTgt[slot(PCF)] : 32'h0;
        if (reset)
            expM = 1'b0;
        else if (BranchE)
            expM = (NeedBranchE != eTaken) || (NeedBranchE && eTgt != PCTargetE);
        else
            expM = eTaken;
        expR = !expM ? 32'h0 : (BranchE && NeedBranchE) ? PCTargetE : PCPlus4E;
        chk({tg, " PredTakenF"}, {31'h0, PredTakenF}, {31'h0, expT});
        chk({tg, " PredTargetF"}, PredTargetF, expTgt);
        chk({tg, " MispredictE"}, {31'h0, MispredictE}, {31'h0, expM});
        chk({tg, " PCRedirectE"}, PCRedirectE, expR);
    endtask

    task automatic modelEdge();
        bit          fT, h;
        logic [31:0] fTgt;
        int          fG, i, b;
        h    = mHit(PCF);
        fT   = h && (mCnt[cntSlot(PCF, mGhr)] >= 2);
        fTgt = h ? mTgt[slot(PCF)] : 32'h0;
        fG   = mGhr;
        if (BranchE && !StallE) begin
            i = slot(PCE);
            b = cntSlot(PCE, eGhr);
            if (NeedBranchE) begin
                mCnt[b]   = mHit(PCE) ? ((mCnt[b] < 3) ? mCnt[b] + 1 : 3) : 2;
                mValid[i] = 1'b1;
                mTag[i]   = PCE / 256;
                mTgt[i]   = PCTargetE;
            end else if (mCnt[b] > 0) begin
                mCnt[b] = mCnt[b] - 1;
            end
            mGhr = (mGhr * 2 + int'(NeedBranchE)) % 64;
        end
        if (FlushE) begin
            eTaken = 0; eTgt = 0; eGhr = 0;
        end else if (!StallE) begin
            eTaken = dTaken; eTgt = dTgt; eGhr = dGhr;
        end
        if (FlushD) begin
            dTaken = 0; dTgt = 0; dGhr = 0;
        end else if (!StallD) begin
            dTaken = fT; dTgt = fTgt; dGhr = fG;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) modelEdge();
        @(negedge clk);
    endtask

    task automatic doReset();
        setIn(32'h100, 0, 0, 0, 0, 32'h100, 1, 1, 32'h80);
        reset = 1'b1;
        modelReset();
        settle("in_reset");
        tick();
        reset = 1'b0;
    endtask

    // Fetch pc, insert a bubble, then present the resolution in E; caller checks and ticks.
    task automatic fetchThenE(input logic [31:0] pc, input logic [31:0] pce, input bit br,
                              input bit nb, input logic [31:0] tgt);
        setIn(pc, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        settle("fetch");
        tick();
        setIn(32'h400, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        settle("bubble");
        tick();
        setIn(32'h400, 0, 0, 0, 0, pce, br, nb, tgt);
        settle("resolve");
    endtask

    initial begin
        int lateMis;
        setIn(32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        reset = 1'b1;
        modelReset();
        @(negedge clk);
        reset = 1'b0;

        // 1: reset state
        setIn(32'h100, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        settle("t1");
        chk("t1 taken", {31'h0, PredTakenF}, 32'h0);
        chk("t1 target", PredTargetF, 32'h0);
        chk("t1 mispredict", {31'h0, MispredictE}, 32'h0);
        tick();

        // 2: first taken resolution
        fetchThenE(32'h100, 32'h100, 1, 1, 32'h80);
        chk("t2 mispredict", {31'h0, MispredictE}, 32'h1);
        chk("t2 redirect", PCRedirectE, 32'h80);
        tick();
        setIn(32'h100, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        settle("t2 lookup");
`ifndef BP_GSHARE_EN
        chk("t2 taken", {31'h0, PredTakenF}, 32'h1);
        chk("t2 target", PredTargetF, 32'h80);
`endif
        tick();

        // 3: saturate, then two not-taken
        for (int k = 0; k < 3; k++) begin
            fetchThenE(32'h100, 32'h100, 1, 1, 32'h80);
`ifndef BP_GSHARE_EN
            chk("t3 taken ok", {31'h0, MispredictE}, 32'h0);
`endif
            tick();
        end
        fetchThenE(32'h100, 32'h100, 1, 0, 32'h0);
`ifndef BP_GSHARE_EN
        chk("t3 nt mispredict", {31'h0, MispredictE}, 32'h1);
        chk("t3 nt redirect", PCRedirectE, 32'h104);
`endif
        tick();
        setIn(32'h100, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        settle("t3 lookup1");
`ifndef BP_GSHARE_EN
        chk("t3 still taken", {31'h0, PredTakenF}, 32'h1);
`endif
        tick();
        fetchThenE(32'h100, 32'h100, 1, 0, 32'h0);
        tick();
        setIn(32'h100, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        settle("t3 lookup2");
`ifndef BP_GSHARE_EN
        chk("t3 now not taken", {31'h0, PredTakenF}, 32'h0);
`endif
        tick();

        // 4: alias on a non-branch
        fetchThenE(32'h100, 32'h100, 1, 1, 32'h80);
        tick();
        fetchThenE(32'h100, 32'h200, 0, 0, 32'h0);
`ifndef BP_GSHARE_EN
        chk("t4 alias mispredict", {31'h0, MispredictE}, 32'h1);
        chk("t4 alias redirect", PCRedirectE, 32'h204);
`endif
        tick();
        setIn(32'h200, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        settle("t4 lookup");
        chk("t4 no write", {31'h0, PredTakenF}, 32'h0);
        tick();

        // 5: stalled E does not train; flush clears E; async reset mid-cycle
        for (int k = 0; k < 3; k++) begin
            setIn(32'h400, 0, 0, 1, 0, 32'h100, 1, 0, 32'h0);
            settle("t5 stall");
            tick();
        end
        setIn(32'h100, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        settle("t5 lookup");
`ifndef BP_GSHARE_EN
        chk("t5 cnt held", {31'h0, PredTakenF}, 32'h1);
`endif
        tick();
        setIn(32'h400, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        settle("t5 bubble");
        tick();
        setIn(32'h400, 0, 0, 0, 1, 32'h0, 0, 0, 32'h0);
        settle("t5 flush");
        tick();
        setIn(32'h400, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        settle("t5 flushed");
        chk("t5 flushed E", {31'h0, MispredictE}, 32'h0);
        tick();
        setIn(32'h100, 0, 0, 0, 0, 32'h100, 1, 1, 32'h80);
        #2;
        reset = 1'b1;
        modelReset();
        settle("t5 reset");
        chk("t5 reset taken", {31'h0, PredTakenF}, 32'h0);
        chk("t5 reset mispredict", {31'h0, MispredictE}, 32'h0);
        chk("t5 reset redirect", PCRedirectE, 32'h0);
        tick();
        reset = 1'b0;
        setIn(32'h100, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        settle("t5 after reset");
        chk("t5 post taken", {31'h0, PredTakenF}, 32'h0);
        chk("t5 post target", PredTargetF, 32'h0);
        tick();

        // 6: alternating pattern
        doReset();
        lateMis = 0;
        for (int n = 0; n < 20; n++) begin
            fetchThenE(32'h100, 32'h100, 1, (n % 2) == 0, 32'h80);
            if (n >= 8) lateMis += int'(MispredictE);
            tick();
        end
`ifdef BP_GSHARE_EN
        chk("t6 gshare learns", lateMis, 32'h0);
`else
        chk("t6 bimodal persists", {31'h0, lateMis > 0}, 32'h1);
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pcf, pce, tgt;
            pcf = ($urandom_range(1, 3) << 8) | ($urandom_range(0, 3) << 2);
            pce = ($urandom_range(1, 3) << 8) | ($urandom_range(0, 3) << 2);
            tgt = {22'h0, $urandom_range(0, 3) == 0 ? 10'h180 : 10'h80};
            if ($urandom_range(0, 149) == 0) begin
                doReset();
            end else begin
                setIn(pcf, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                      pce, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, tgt);
                settle("rand");
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
